// File: rtl/deploy_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : deploy_scheduler                                                  |
// | Brief  : Card-hand deployment sequencer. Arms a card on keypress, deploys  |
// |          it on an in-field mouse click when enough elixir is held, and     |
// |          recycles dead units back to the hand. Elixir regenerates once per |
// |          REGEN_FRAMES vsync frames.                                        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module deploy_scheduler #(
  parameter int                   N_UNITS      = 5,
  parameter logic [4*N_UNITS-1:0] COST         = {4'd3, 4'd3, 4'd3, 4'd3, 4'd4},
  parameter int                   MAX_ELIXIR   = 10,
  parameter int                   START_ELIXIR = 5,
  parameter int                   REGEN_FRAMES = 60,
  parameter int                   FIELD_XMIN   = 16,
  parameter int                   FIELD_XMAX   = 520,
  parameter int                   FIELD_YMIN   = 32,
  parameter int                   FIELD_YMAX   = 447
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic [N_UNITS-1:0] card_key,
  input  logic               cancel,
  input  logic               mouse_click,
  input  logic [9:0]         MouseX,
  input  logic [9:0]         MouseY,
  input  logic [N_UNITS-1:0] infield,
  output logic [N_UNITS-1:0] instate,
  output logic [N_UNITS-1:0] deploy,
  output logic [N_UNITS-1:0] idle,
  output logic [3:0]         elixir,
  output logic [2:0]         sel,
  output logic               busy
);

  localparam int             FC_W      = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  localparam logic [FC_W-1:0] C_FC_LAST = FC_W'(REGEN_FRAMES - 1);
  localparam logic [4:0]     C_MAX5    = 5'(MAX_ELIXIR);
  localparam logic [3:0]     C_START   = 4'(START_ELIXIR);
  localparam logic [9:0]     C_XMIN    = 10'(FIELD_XMIN);
  localparam logic [9:0]     C_XMAX    = 10'(FIELD_XMAX);
  localparam logic [9:0]     C_YMIN    = 10'(FIELD_YMIN);
  localparam logic [9:0]     C_YMAX    = 10'(FIELD_YMAX);

  // RELEASE keeps deploy asserted for the cycle after the frame tick so the
  // sprite unit samples a stable request on its own vsync rising edge.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_DEPLOY  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [N_UNITS-1:0]   instate_q, instate_d;
  logic [N_UNITS-1:0]   deploy_q, deploy_d;
  logic                 busy_q, busy_d;
  logic [3:0]           elixir_q, elixir_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [N_UNITS-1:0]   avail_q, avail_d;
  logic [N_UNITS-1:0]   seen_q, seen_d;
  logic [N_UNITS-1:0]   idle_pend_q, idle_pend_d;
  logic [N_UNITS-1:0]   idle_rel_q, idle_rel_d;
  logic                 vsync_q, click_q;

  logic                 frame_tick, click, in_field, charge, wrap, regen_inc;
  logic [N_UNITS-1:0]   eligible, sel_onehot;
  logic [2:0]           pick;
  logic [3:0]           cost_a [N_UNITS];
  logic [3:0]           cost_sel;
  logic [4:0]           elixir_sum;

  assign frame_tick = vsync & ~vsync_q;
  assign click      = mouse_click & ~click_q;
  assign in_field   = (MouseX >= C_XMIN) && (MouseX <= C_XMAX) &&
                      (MouseY >= C_YMIN) && (MouseY <= C_YMAX);
  assign cost_sel   = cost_a[sel_q];

  generate
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
      assign cost_a[gi]   = COST[4*gi +: 4];
      assign eligible[gi] = card_key[gi] & avail_q[gi] & (elixir_q >= COST[4*gi +: 4]);
    end
  endgenerate

  // Lowest-index eligible card wins.
  always_comb begin
    pick = 3'd0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (eligible[i]) pick = 3'(i);
    end
  end

  // Card FSM: next state, selection and deploy charge strobe.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    charge  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_d = 3'd0;
        if (|eligible) begin
          state_d = S_ARMED;
          sel_d   = pick;
        end
      end
      S_ARMED: begin
        if (cancel) begin
          state_d = S_IDLE;
          sel_d   = 3'd0;
        end else if (click && in_field && (elixir_q >= cost_sel)) begin
          state_d = S_DEPLOY;
          charge  = 1'b1;
        end else if ((|eligible) && (pick != sel_q)) begin
          sel_d = pick;
        end
      end
      S_DEPLOY: begin
        if (frame_tick) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
      end
    endcase
  end

  // Registered per-unit controls follow the next state.
  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_d] = 1'b1;
    instate_d = (state_d == S_ARMED) ? sel_onehot : '0;
    deploy_d  = ((state_d == S_DEPLOY) || (state_d == S_RELEASE)) ? sel_onehot : '0;
    busy_d    = (state_d != S_IDLE);
  end

  // Unit lifecycle: observe on field, detect death, hold idle across a frame.
  always_comb begin
    avail_d     = avail_q;
    seen_d      = seen_q;
    idle_pend_d = idle_pend_q;
    idle_rel_d  = idle_rel_q;
    for (int i = 0; i < N_UNITS; i++) begin
      if (idle_rel_q[i]) begin
        idle_pend_d[i] = 1'b0;
        idle_rel_d[i]  = 1'b0;
        avail_d[i]     = 1'b1;
      end else if (idle_pend_q[i] && frame_tick) begin
        idle_rel_d[i] = 1'b1;
      end
      if (seen_q[i] && !infield[i]) begin
        seen_d[i]      = 1'b0;
        idle_pend_d[i] = 1'b1;
      end else if (infield[i] && !avail_q[i] && !idle_pend_q[i]) begin
        seen_d[i] = 1'b1;
      end
    end
    // A fresh deploy always takes the card out of the hand.
    if (charge) avail_d[sel_q] = 1'b0;
  end

  // Elixir regeneration and deploy charge; a regen landing with a charge is
  // always credited, then the result saturates at MAX_ELIXIR.
  always_comb begin
    wrap        = frame_tick && (frame_cnt_q == C_FC_LAST);
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) frame_cnt_d = wrap ? '0 : frame_cnt_q + 1'b1;
    regen_inc   = wrap && (charge || ({1'b0, elixir_q} < C_MAX5));
    elixir_sum  = {1'b0, elixir_q} + {4'b0, regen_inc} - (charge ? {1'b0, cost_sel} : 5'd0);
    elixir_d    = (elixir_sum > C_MAX5) ? C_MAX5[3:0] : elixir_sum[3:0];
  end

  // State and output registers.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      instate_q   <= '0;
      deploy_q    <= '0;
      busy_q      <= 1'b0;
      elixir_q    <= C_START;
      frame_cnt_q <= '0;
      avail_q     <= '1;
      seen_q      <= '0;
      idle_pend_q <= '1;
      idle_rel_q  <= '0;
      vsync_q     <= 1'b0;
      click_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      instate_q   <= instate_d;
      deploy_q    <= deploy_d;
      busy_q      <= busy_d;
      elixir_q    <= elixir_d;
      frame_cnt_q <= frame_cnt_d;
      avail_q     <= avail_d;
      seen_q      <= seen_d;
      idle_pend_q <= idle_pend_d;
      idle_rel_q  <= idle_rel_d;
      vsync_q     <= vsync;
      click_q     <= mouse_click;
    end
  end

  assign instate = instate_q;
  assign deploy  = deploy_q;
  assign idle    = idle_pend_q;
  assign elixir  = elixir_q;
  assign sel     = sel_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_deploy_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_deploy_scheduler                                               |
// | Brief  : Scoreboard bench for deploy_scheduler: arm/deploy/cancel flow,    |
// |          elixir regeneration and saturation, unit recycling, async reset.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_deploy_scheduler;

  localparam int N = 5;
  localparam int C_SIG_INSTATE = 0;
  localparam int C_SIG_DEPLOY  = 1;
  localparam int C_SIG_IDLE    = 2;
  localparam int C_SIG_ELIXIR  = 3;
  localparam int C_SIG_SEL     = 4;
  localparam int C_SIG_BUSY    = 5;

  logic         vga_clk = 1'b0;
  logic         reset = 1'b0;
  logic         vsync = 1'b0;
  logic [N-1:0] card_key = '0;
  logic         cancel = 1'b0;
  logic         mouse_click = 1'b0;
  logic [9:0]   MouseX = '0;
  logic [9:0]   MouseY = '0;
  logic [N-1:0] infield = '0;
  logic [N-1:0] instate, deploy, idle;
  logic [3:0]   elixir;
  logic [2:0]   sel;
  logic         busy;

  always #5 vga_clk = ~vga_clk;

  deploy_scheduler #(
    .N_UNITS (N),
    .COST    ({4'd4, 4'd3, 4'd3, 4'd3, 4'd3})
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .vsync       (vsync),
    .card_key    (card_key),
    .cancel      (cancel),
    .mouse_click (mouse_click),
    .MouseX      (MouseX),
    .MouseY      (MouseY),
    .infield     (infield),
    .instate     (instate),
    .deploy      (deploy),
    .idle        (idle),
    .elixir      (elixir),
    .sel         (sel),
    .busy        (busy)
  );

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e_m  = 5;   // elixir model
  int   fc_m = 0;   // frame counter model

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      C_SIG_INSTATE: return 32'(instate);
      C_SIG_DEPLOY:  return 32'(deploy);
      C_SIG_IDLE:    return 32'(idle);
      C_SIG_ELIXIR:  return 32'(elixir);
      C_SIG_SEL:     return 32'(sel);
      default:       return 32'(busy);
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), 32'(e.val));
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    drain();
  endtask

  task automatic frame_model();
    if (fc_m == 59) begin
      fc_m = 0;
      if (e_m < 10) e_m++;
    end else begin
      fc_m++;
    end
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    frame_model();
    vsync = 1'b0;
    step();
    step();
  endtask

  task automatic click_at(input int x, input int y);
    MouseX      = 10'(x);
    MouseY      = 10'(y);
    mouse_click = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held low.
    repeat (3) @(posedge vga_clk);
    #1;
    expect_sig("rst_idle", C_SIG_IDLE, 31);
    expect_sig("rst_elixir", C_SIG_ELIXIR, 5);
    expect_sig("rst_busy", C_SIG_BUSY, 0);
    expect_sig("rst_instate", C_SIG_INSTATE, 0);
    expect_sig("rst_deploy", C_SIG_DEPLOY, 0);
    expect_sig("rst_sel", C_SIG_SEL, 0);
    drain();
    reset = 1'b1;
    expect_sig("idle_hold", C_SIG_IDLE, 31);
    step();
    frame();
    expect_sig("idle_clear", C_SIG_IDLE, 0);
    expect_sig("elixir_start", C_SIG_ELIXIR, 5);
    step();

    // Arm and deploy unit 2.
    card_key = 5'b00100;
    expect_sig("arm2_instate", C_SIG_INSTATE, 4);
    expect_sig("arm2_sel", C_SIG_SEL, 2);
    expect_sig("arm2_busy", C_SIG_BUSY, 1);
    step();
    card_key = '0;
    click_at(200, 200);
    e_m -= 3;
    expect_sig("dep2_deploy", C_SIG_DEPLOY, 4);
    expect_sig("dep2_instate", C_SIG_INSTATE, 0);
    expect_sig("dep2_elixir", C_SIG_ELIXIR, e_m);
    step();
    mouse_click = 1'b0;
    vsync = 1'b1;
    expect_sig("dep2_hold_f1", C_SIG_DEPLOY, 4);
    step();
    frame_model();
    vsync = 1'b0;
    expect_sig("dep2_off", C_SIG_DEPLOY, 0);
    expect_sig("dep2_busy_off", C_SIG_BUSY, 0);
    expect_sig("dep2_sel_off", C_SIG_SEL, 0);
    step();
    step();

    // Unavailable card and insufficient elixir are both ignored.
    card_key = 5'b00100;
    expect_sig("reuse2_busy", C_SIG_BUSY, 0);
    step();
    card_key = 5'b00001;
    expect_sig("poor0_busy", C_SIG_BUSY, 0);
    expect_sig("poor0_instate", C_SIG_INSTATE, 0);
    step();
    card_key = '0;

    // Regenerate one elixir over a full regen period.
    while (fc_m != 0) frame();
    expect_sig("regen_elixir", C_SIG_ELIXIR, e_m);
    step();
    check_eq("regen_model", 32'(e_m), 32'd3);

    // Arm 0, re-arm to 1, outside clicks ignored, cancel beats click.
    card_key = 5'b00001;
    expect_sig("arm0_instate", C_SIG_INSTATE, 1);
    expect_sig("arm0_sel", C_SIG_SEL, 0);
    step();
    card_key = 5'b00010;
    expect_sig("rearm1_instate", C_SIG_INSTATE, 2);
    expect_sig("rearm1_sel", C_SIG_SEL, 1);
    step();
    card_key = '0;
    click_at(600, 40);
    expect_sig("outclick_busy", C_SIG_BUSY, 1);
    expect_sig("outclick_instate", C_SIG_INSTATE, 2);
    expect_sig("outclick_elixir", C_SIG_ELIXIR, e_m);
    step();
    mouse_click = 1'b0;
    step();
    click_at(521, 100);
    expect_sig("edgeclick_busy", C_SIG_BUSY, 1);
    expect_sig("edgeclick_deploy", C_SIG_DEPLOY, 0);
    step();
    mouse_click = 1'b0;
    step();
    click_at(100, 100);
    cancel = 1'b1;
    expect_sig("cancel_busy", C_SIG_BUSY, 0);
    expect_sig("cancel_deploy", C_SIG_DEPLOY, 0);
    expect_sig("cancel_elixir", C_SIG_ELIXIR, e_m);
    step();
    mouse_click = 1'b0;
    cancel = 1'b0;
    step();

    // Deploy unit 3 at the field corner, then let it die and recycle.
    card_key = 5'b01000;
    expect_sig("arm3_sel", C_SIG_SEL, 3);
    step();
    card_key = '0;
    click_at(520, 447);
    e_m -= 3;
    expect_sig("dep3_deploy", C_SIG_DEPLOY, 8);
    expect_sig("dep3_elixir", C_SIG_ELIXIR, e_m);
    step();
    mouse_click = 1'b0;
    frame();
    expect_sig("dep3_off", C_SIG_DEPLOY, 0);
    step();
    infield = 5'b01000;
    step();
    expect_sig("alive3_idle", C_SIG_IDLE, 0);
    step();
    infield = '0;
    expect_sig("dead3_idle", C_SIG_IDLE, 8);
    step();
    expect_sig("dead3_idle_hold", C_SIG_IDLE, 8);
    step();
    frame();
    expect_sig("dead3_idle_clear", C_SIG_IDLE, 0);
    step();
    while (e_m < 3) frame();
    card_key = 5'b01000;
    expect_sig("rearm3_instate", C_SIG_INSTATE, 8);
    expect_sig("rearm3_sel", C_SIG_SEL, 3);
    step();
    card_key = '0;
    cancel = 1'b1;
    expect_sig("rearm3_cancel", C_SIG_BUSY, 0);
    step();
    cancel = 1'b0;

    // Saturation at MAX_ELIXIR.
    while (e_m < 10) frame();
    expect_sig("sat_reach", C_SIG_ELIXIR, 10);
    step();
    repeat (120) frame();
    expect_sig("sat_hold", C_SIG_ELIXIR, 10);
    step();

    // Deploy of unit 4 (cost 4) coinciding with a regen wrap.
    while (fc_m != 59) frame();
    card_key = 5'b10000;
    expect_sig("arm4_instate", C_SIG_INSTATE, 16);
    step();
    card_key = '0;
    click_at(300, 300);
    vsync = 1'b1;
    e_m = e_m + 1 - 4;
    if (e_m > 10) e_m = 10;
    fc_m = 0;
    expect_sig("coincide_deploy", C_SIG_DEPLOY, 16);
    expect_sig("coincide_elixir", C_SIG_ELIXIR, e_m);
    step();
    mouse_click = 1'b0;
    vsync = 1'b0;
    step();

    // Asynchronous reset while deploying.
    reset = 1'b0;
    #1;
    expect_sig("async_deploy", C_SIG_DEPLOY, 0);
    expect_sig("async_elixir", C_SIG_ELIXIR, 5);
    expect_sig("async_busy", C_SIG_BUSY, 0);
    expect_sig("async_idle", C_SIG_IDLE, 31);
    drain();
    step();
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/deploy_scheduler.md
# deploy_scheduler

Sequences troop deployment for the player's card hand: takes card keypresses and mouse clicks, checks elixir, and drives the per-unit `instatein` / `deployin` / `idlein` controls of the N troop sprite units. It also tracks each unit's lifecycle and recycles dead units back to the hand. It sits between the keyboard/mouse front end and the troop sprite modules. Elixir is kept in the `vga_clk` domain and counted in frames.

## Interface
- N_UNITS, 5: number of troop units / cards.
- COST, {4'd3,4'd3,4'd3,4'd3,4'd4}: packed 4-bit elixir cost per unit. Unit 0 is in the LSBs.
- MAX_ELIXIR, 10: saturation value.
- START_ELIXIR, 5: value loaded on reset.
- REGEN_FRAMES, 60: vsync frames per +1 elixir.
- FIELD_XMIN / FIELD_XMAX, 16 / 520: inclusive legal drop X range.
- FIELD_YMIN / FIELD_YMAX, 32 / 447: inclusive legal drop Y range.
- vga_clk  in  1  pixel clock; sole clock.
- reset  in  1  asynchronous, active-low.
- vsync  in  1  frame sync, synchronous to vga_clk; the rising edge is the frame tick.
- card_key  in  N_UNITS  one-cycle card select pulses.
- cancel  in  1  one-cycle pulse; aborts an armed card.
- mouse_click  in  1  level; the rising edge is a click.
- MouseX, MouseY  in  10  cursor position.
- infield  in  N_UNITS  unit-reported "on field and alive".
- instate  out  N_UNITS  unit follows the cursor (preview).
- deploy  out  N_UNITS  deploy request, held across one vsync rise.
- idle  out  N_UNITS  unit reset request, held across one vsync rise.
- elixir  out  4  current elixir.
- sel  out  3  armed/deploying unit index (0 when IDLE).
- busy  out  1  high in ARMED or DEPLOY.

## Operation
- Edge detect: register vsync and mouse_click. frame_tick = vsync & ~vsync_q. click = mouse_click & ~click_q.
- Per-unit state: avail[i] (in hand) and seen[i] (infield observed after deploy).
- FSM IDLE:
  - eligible[i] = card_key[i] & avail[i] & (elixir >= COST[i]).
  - If any eligible, the lowest index wins: sel <= i, go to ARMED.
  - An ineligible key is ignored.
- FSM ARMED:
  - instate[sel] = 1.
  - cancel -> IDLE, no charge. cancel has priority over a click in the same cycle.
  - An eligible card_key with a different index re-arms to that index.
  - A click with the cursor inside the field rectangle -> DEPLOY. On that cycle: elixir -= COST[sel], avail[sel] <= 0.
  - A click outside the rectangle is ignored.
- FSM DEPLOY:
  - deploy[sel] = 1, instate = 0.
  - On frame_tick, go to IDLE the next cycle. deploy therefore stays stable across the unit's posedge vsync sample.
  - card_key and cancel are ignored in DEPLOY.
- Lifecycle:
  - When infield[i] = 1 and avail[i] = 0, set seen[i].
  - When seen[i] = 1 and infield[i] = 0 (unit died), set idle_pend[i] and clear seen[i].
  - idle[i] = idle_pend[i]. It clears on the cycle after the next frame_tick, and avail[i] <= 1 at the same time.
  - Any number of units may recycle concurrently, independent of the FSM.
- Elixir:
  - frame_cnt counts frame_tick events, 0..REGEN_FRAMES-1, then wraps.
  - On wrap, elixir += 1 if elixir < MAX_ELIXIR.
  - If a regen and a deploy charge land in the same cycle, elixir <= min(elixir + 1 - COST[sel], MAX_ELIXIR). It never underflows, because eligibility is rechecked at click time.
  - Arithmetic is in 5 bits, then truncated to 4.

## Timing
- Reset (asserted low) values:
  - FSM = IDLE, sel = 0, busy = 0, instate = 0, deploy = 0.
  - elixir = START_ELIXIR, frame_cnt = 0.
  - avail = all 1, seen = 0.
  - idle = all 1 (idle_pend preset), so every unit is forced to its idle state at the first frame after reset release.
- Reset mid-DEPLOY drops deploy immediately (async). The charge already taken is discarded by the START_ELIXIR reload.
- All outputs are registered, changing 1 cycle after the causing input edge.
- card_key -> instate: 1 cycle.
- click -> deploy: 1 cycle.
- deploy high duration: from the click cycle + 1 up to and including the frame_tick cycle + 1.
- idle[i] rises 1 cycle after infield[i] falls.

## Test plan
- After reset: idle = 5'b11111 until the first frame_tick + 1, then 0. elixir = 5, busy = 0.
- card_key[2] -> instate[2] next cycle. Click at (200,200) -> deploy[2] high until the frame_tick + 1, then elixir = 2 and avail[2] = 0. A second card_key[2] while avail[2] = 0 is ignored.
- With elixir = 2, card_key[0] (cost 3) -> stays IDLE. Run 60 frames -> elixir = 3. card_key[0] now arms.
- Armed unit 1, click at (600,40) (outside field) -> stays ARMED, no charge. cancel in the same cycle as a click inside the field -> IDLE, elixir unchanged.
- Deployed unit 3: infield[3] rises then falls -> idle[3] high for one frame, then avail[3] = 1 and card_key[3] arms it again.
- elixir = 10 for 120 frames -> stays 10. A deploy (cost 4) coinciding with a regen wrap -> elixir = 7. Reset asserted in DEPLOY -> deploy = 0 asynchronously and elixir = 5.
